// File: rtl/bram_arbiter.sv
// bram_arbiter: shares one single-port block RAM between requesters A and B.
// Round-robin on ties. A per-side lock keeps ownership for read-modify-write
// sequences. A grant counter forces release after MAXLOCK locked grants.
module bram_arbiter #(
  parameter  int NCELLS  = 1024,
  parameter  int WDATA   = 8,
  parameter  int MAXLOCK = 16,
  localparam int AW      = $clog2(NCELLS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_a_req,
  input  logic             i_a_wr,
  input  logic             i_a_lock,
  input  logic [AW-1:0]    i_a_addr,
  input  logic [WDATA-1:0] i_a_din,
  input  logic             i_b_req,
  input  logic             i_b_wr,
  input  logic             i_b_lock,
  input  logic [AW-1:0]    i_b_addr,
  input  logic [WDATA-1:0] i_b_din,
  output logic             o_a_ack,
  output logic             o_b_ack,
  output logic             o_a_rvalid,
  output logic             o_b_rvalid,
  output logic [WDATA-1:0] o_a_dout,
  output logic [WDATA-1:0] o_b_dout,
  output logic [AW-1:0]    o_mem_addr,
  output logic [WDATA-1:0] o_mem_din,
  output logic             o_mem_wr,
  input  logic [WDATA-1:0] i_mem_dout
);

  // The counter must be able to hold MAXLOCK itself; keep at least one bit
  // so the unlimited setting (MAXLOCK = 0) still elaborates.
  localparam int CW = (MAXLOCK < 1) ? 1 : $clog2(MAXLOCK + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_LIM = CW'(MAXLOCK);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOCK_A = 2'd1;
  localparam logic [1:0] S_LOCK_B = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_state_next;
  logic          r_last;          // 1 = B was granted most recently
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic [CW-1:0] w_cnt_inc;
  logic          w_timeout;
  logic          r_rv_a;
  logic          r_rv_b;
  logic          w_a_ack;
  logic          w_b_ack;

  // Winner selection: a lock owner is exclusive, otherwise round-robin on ties.
  // Reset gates both grants so nothing reaches the memory while held in reset.
  always_comb begin
    w_a_ack = 1'b0;
    w_b_ack = 1'b0;
    if (i_rst_n) begin
      case (r_state)
        S_IDLE: begin
          if (i_a_req && (!i_b_req || r_last)) w_a_ack = 1'b1;
          else if (i_b_req)                    w_b_ack = 1'b1;
        end
        S_LOCK_A: w_a_ack = i_a_req;
        S_LOCK_B: w_b_ack = i_b_req;
        default: begin
          w_a_ack = 1'b0;
          w_b_ack = 1'b0;
        end
      endcase
    end
  end

  // Memory port mux; when idle the A-side address/data is parked on the bus.
  always_comb begin
    o_mem_addr = i_a_addr;
    o_mem_din  = i_a_din;
    o_mem_wr   = 1'b0;
    if (w_a_ack) begin
      o_mem_wr = i_a_wr;
    end else if (w_b_ack) begin
      o_mem_addr = i_b_addr;
      o_mem_din  = i_b_din;
      o_mem_wr   = i_b_wr;
    end
  end

  // Lock state machine; timeout is taken on the grant that reaches the limit
  // so the other side can win the very next cycle.
  always_comb begin
    w_cnt_inc    = (r_state == S_IDLE) ? CW'(1) :
                   ((r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1));
    w_timeout    = (MAXLOCK != 0) && (w_cnt_inc >= CNT_LIM);
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (((w_a_ack && i_a_lock) || (w_b_ack && i_b_lock)) && !w_timeout) begin
          w_state_next = w_a_ack ? S_LOCK_A : S_LOCK_B;
          w_cnt_next   = w_cnt_inc;
        end
      end
      S_LOCK_A: begin
        if (!i_a_lock || (w_a_ack && w_timeout)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_a_ack) begin
          w_cnt_next = w_cnt_inc;
        end
      end
      S_LOCK_B: begin
        if (!i_b_lock || (w_b_ack && w_timeout)) begin
          w_state_next = S_IDLE;
          w_cnt_next   = '0;
        end else if (w_b_ack) begin
          w_cnt_next = w_cnt_inc;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // State, round-robin pointer, lock counter and response owner tags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_last  <= 1'b1;
      r_cnt   <= '0;
      r_rv_a  <= 1'b0;
      r_rv_b  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rv_a  <= w_a_ack;
      r_rv_b  <= w_b_ack;
      if (w_a_ack)      r_last <= 1'b0;
      else if (w_b_ack) r_last <= 1'b1;
    end
  end

  assign o_a_ack    = w_a_ack;
  assign o_b_ack    = w_b_ack;
  assign o_a_rvalid = r_rv_a;
  assign o_b_rvalid = r_rv_b;
  assign o_a_dout   = r_rv_a ? i_mem_dout : '0;
  assign o_b_dout   = r_rv_b ? i_mem_dout : '0;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a write-first single-port RAM model.
module tb_bram_arbiter;

  localparam int AW = 10;
  localparam int DW = 8;

  logic          clk;
  logic          i_rst_n;
  logic          a_req, a_wr, a_lock, b_req, b_wr, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_din, b_din;
  logic          a_ack, b_ack, a_rvalid, b_rvalid;
  logic [DW-1:0] a_dout, b_dout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  logic          mem_wr;

  logic [DW-1:0] ram    [0:1023];
  logic [DW-1:0] shadow [0:1023];

  typedef struct {
    logic          side;   // 0 = A, 1 = B
    logic [DW-1:0] data;
  } resp_t;
  resp_t q[$];

  int checks = 0;
  int errors = 0;

  bram_arbiter #(.NCELLS(1024), .WDATA(DW), .MAXLOCK(4)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n),
    .i_a_req(a_req), .i_a_wr(a_wr), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_din(a_din),
    .i_b_req(b_req), .i_b_wr(b_wr), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_din(b_din),
    .o_a_ack(a_ack), .o_b_ack(b_ack), .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
    .o_a_dout(a_dout), .o_b_dout(b_dout),
    .o_mem_addr(mem_addr), .o_mem_din(mem_din), .o_mem_wr(mem_wr), .i_mem_dout(mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'(i * 7 + 3);
  end

  // Write-first block RAM with one cycle read latency.
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_addr] <= mem_din;
      mem_dout      <= mem_din;
    end else begin
      mem_dout <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_check(input logic ar, input logic aw, input logic al,
                             input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                             input logic br, input logic bw, input logic bl,
                             input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                             input logic ea, input logic eb);
    resp_t r;
    a_req = ar; a_wr = aw; a_lock = al; a_addr = aa; a_din = ad;
    b_req = br; b_wr = bw; b_lock = bl; b_addr = ba; b_din = bd;
    #1;
    check("a_ack", 32'(a_ack), 32'(ea));
    check("b_ack", 32'(b_ack), 32'(eb));
    if (ea) begin
      check("mem_wr_a", 32'(mem_wr), 32'(aw));
      check("mem_addr_a", 32'(mem_addr), 32'(aa));
      if (aw) begin
        check("mem_din_a", 32'(mem_din), 32'(ad));
        shadow[aa] = ad;
      end
      r.side = 1'b0; r.data = shadow[aa];
      q.push_back(r);
    end else if (eb) begin
      check("mem_wr_b", 32'(mem_wr), 32'(bw));
      check("mem_addr_b", 32'(mem_addr), 32'(ba));
      if (bw) begin
        check("mem_din_b", 32'(mem_din), 32'(bd));
        shadow[ba] = bd;
      end
      r.side = 1'b1; r.data = shadow[ba];
      q.push_back(r);
    end else begin
      check("mem_wr_idle", 32'(mem_wr), 32'(0));
    end
  endtask

  task automatic resp_check();
    resp_t r;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      r = q.pop_front();
      check("a_rvalid", 32'(a_rvalid), 32'(!r.side));
      check("b_rvalid", 32'(b_rvalid), 32'(r.side));
      if (r.side) check("b_dout", 32'(b_dout), 32'(r.data));
      else        check("a_dout", 32'(a_dout), 32'(r.data));
    end else begin
      check("a_rvalid_idle", 32'(a_rvalid), 32'(0));
      check("b_rvalid_idle", 32'(b_rvalid), 32'(0));
    end
  endtask

  task automatic step(input logic ar, input logic aw, input logic al,
                      input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic br, input logic bw, input logic bl,
                      input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input logic ea, input logic eb);
    drive_check(ar, aw, al, aa, ad, br, bw, bl, ba, bd, ea, eb);
    resp_check();
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) shadow[i] = 8'(i * 7 + 3);
    i_rst_n = 1'b0;
    a_req = 1'b1; a_wr = 1'b1; a_lock = 1'b0; a_addr = '0; a_din = '0;
    b_req = 1'b1; b_wr = 1'b1; b_lock = 1'b0; b_addr = '0; b_din = '0;

    // Held in reset with requests pending: nothing granted, nothing written.
    repeat (2) @(negedge clk);
    #1;
    check("rst_a_ack", 32'(a_ack), 32'(0));
    check("rst_b_ack", 32'(b_ack), 32'(0));
    check("rst_mem_wr", 32'(mem_wr), 32'(0));
    check("rst_a_rvalid", 32'(a_rvalid), 32'(0));
    check("rst_b_rvalid", 32'(b_rvalid), 32'(0));
    @(negedge clk);
    i_rst_n = 1'b1;

    // Both read 5/6: A first (reset tie-break), then B.
    step(1, 0, 0, 10'd5, 8'h00, 1, 0, 0, 10'd6, 8'h00, 1, 0);
    step(0, 0, 0, 10'd0, 8'h00, 1, 0, 0, 10'd6, 8'h00, 0, 1);

    // Continuous contention: strict alternation A,B,A,B...
    for (int i = 0; i < 8; i++)
      step(1, 0, 0, 10'(100 + i), 8'h00, 1, 0, 0, 10'(200 + i), 8'h00, (i % 2) == 0, (i % 2) == 1);

    // A writes 0xA5 to 3, B reads 3 the next cycle.
    step(1, 1, 0, 10'd3, 8'hA5, 0, 0, 0, 10'd0, 8'h00, 1, 0);
    step(0, 0, 0, 10'd0, 8'h00, 1, 0, 0, 10'd3, 8'h00, 0, 1);

    // A locks; B stalls through grants, idle-with-lock, and the release cycle.
    step(1, 0, 1, 10'd7, 8'h00, 1, 0, 0, 10'd8, 8'h00, 1, 0);
    step(1, 0, 1, 10'd9, 8'h00, 1, 0, 0, 10'd8, 8'h00, 1, 0);
    step(0, 0, 1, 10'd0, 8'h00, 1, 0, 0, 10'd8, 8'h00, 0, 0);
    step(0, 0, 0, 10'd0, 8'h00, 1, 0, 0, 10'd8, 8'h00, 0, 0);
    step(0, 0, 0, 10'd0, 8'h00, 1, 0, 0, 10'd8, 8'h00, 0, 1);

    // Lock timeout after 4 grants: B wins the 5th, then A relocks.
    for (int i = 0; i < 4; i++)
      step(1, 0, 1, 10'(300 + i), 8'h00, 1, 0, 0, 10'd30, 8'h00, 1, 0);
    step(1, 0, 1, 10'd310, 8'h00, 1, 0, 0, 10'd30, 8'h00, 0, 1);
    step(1, 1, 1, 10'd40, 8'h3C, 0, 0, 0, 10'd0, 8'h00, 1, 0);

    // Owner requests while releasing: still granted, release next cycle.
    step(1, 0, 0, 10'd40, 8'h00, 1, 0, 0, 10'd42, 8'h00, 1, 0);
    step(1, 0, 0, 10'd41, 8'h00, 1, 0, 0, 10'd42, 8'h00, 0, 1);
    step(1, 0, 0, 10'd41, 8'h00, 0, 0, 0, 10'd0, 8'h00, 1, 0);

    // Reset mid-stream: response cleared at once, A wins the first tie after.
    drive_check(1, 0, 0, 10'd50, 8'h00, 0, 0, 0, 10'd0, 8'h00, 1, 0);
    resp_check();
    a_req = 1'b1; b_req = 1'b1; a_wr = 1'b0; b_wr = 1'b0;
    i_rst_n = 1'b0;
    #1;
    check("mid_rst_a_rvalid", 32'(a_rvalid), 32'(0));
    check("mid_rst_b_rvalid", 32'(b_rvalid), 32'(0));
    check("mid_rst_a_ack", 32'(a_ack), 32'(0));
    check("mid_rst_b_ack", 32'(b_ack), 32'(0));
    check("mid_rst_mem_wr", 32'(mem_wr), 32'(0));
    q.delete();
    @(negedge clk);
    i_rst_n = 1'b1;
    step(1, 0, 0, 10'd60, 8'h00, 1, 0, 0, 10'd61, 8'h00, 1, 0);
    step(0, 0, 0, 10'd0, 8'h00, 1, 0, 0, 10'd61, 8'h00, 0, 1);
    step(0, 0, 0, 10'd0, 8'h00, 0, 0, 0, 10'd0, 8'h00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
